// File: rtl/ex_mc_alu.sv
// Execute stage: single-cycle logic/shift/add/compare ops plus an iterative
// radix-2 restoring divider that writes HI/LO. All results are registered,
// so the downstream stage sees one result beat per accepted op.
// Handshake: an op is taken at a rising edge when valid_i & ready_o & ~flush_i;
// ready_o is high exactly when no divide is in flight.
module ex_mc_alu #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            aluOp_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o
);

    localparam int SHAMT_W = $clog2(DATA_W);

    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_ADDU = 4'd8;
    localparam logic [3:0] OP_SUBU = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;

    typedef enum logic [0:0] {IDLE, DIV_BUSY} state_t;

    state_t               state, state_next;
    logic [SHAMT_W-1:0]   counter;
    logic [DATA_W-1:0]    rem_q, quo_q, dvs_q;
    logic                 neg_quo_q, neg_rem_q;

    logic                 accept, is_div, div_zero, start_div, last_iter;
    logic [SHAMT_W-1:0]   shamt;
    logic [DATA_W-1:0]    alu_res;
    logic                 dvd_neg, dvs_neg;
    logic [DATA_W-1:0]    dvd_mag, dvs_mag;
    logic [DATA_W:0]      trial;
    logic                 ge;
    logic [DATA_W-1:0]    diff, rem_next, quo_next, quo_fix, rem_fix;

    assign ready_o   = (state == IDLE);
    assign accept    = valid_i & ready_o & ~flush_i;
    assign is_div    = (aluOp_i == OP_DIV) || (aluOp_i == OP_DIVU);
    assign div_zero  = (reg2_i == '0);
    assign start_div = accept & is_div & ~div_zero;
    assign last_iter = (counter == SHAMT_W'(DATA_W - 1));
    assign shamt     = reg1_i[SHAMT_W-1:0];

    // Single-cycle result; NOP, 14, 15 and divide codes produce zero here.
    always_comb begin
        alu_res = '0;
        case (aluOp_i)
            OP_OR:   alu_res = reg1_i | reg2_i;
            OP_AND:  alu_res = reg1_i & reg2_i;
            OP_XOR:  alu_res = reg1_i ^ reg2_i;
            OP_NOR:  alu_res = ~(reg1_i | reg2_i);
            OP_SLL:  alu_res = reg2_i << shamt;
            OP_SRL:  alu_res = reg2_i >> shamt;
            OP_SRA:  alu_res = $signed(reg2_i) >>> shamt;
            OP_ADDU: alu_res = reg1_i + reg2_i;
            OP_SUBU: alu_res = reg1_i - reg2_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes for the divider; only DIV treats operands as signed.
    always_comb begin
        dvd_neg = (aluOp_i == OP_DIV) & reg1_i[DATA_W-1];
        dvs_neg = (aluOp_i == OP_DIV) & reg2_i[DATA_W-1];
        dvd_mag = dvd_neg ? (~reg1_i + 1'b1) : reg1_i;
        dvs_mag = dvs_neg ? (~reg2_i + 1'b1) : reg2_i;
    end

    // One restoring step: shift next dividend bit into the partial remainder,
    // subtract the divisor when it fits. The remainder always stays below the
    // divisor, so DATA_W bits suffice once trial's top bit feeds the compare.
    always_comb begin
        trial    = {rem_q, quo_q[DATA_W-1]};
        ge       = trial[DATA_W] | (trial[DATA_W-1:0] >= dvs_q);
        diff     = trial[DATA_W-1:0] - dvs_q;
        rem_next = ge ? diff : trial[DATA_W-1:0];
        quo_next = {quo_q[DATA_W-2:0], ge};
        quo_fix  = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
        rem_fix  = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // FSM next state: flush dominates; divide-by-zero never enters DIV_BUSY.
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (start_div) state_next = DIV_BUSY;
                DIV_BUSY: if (last_iter) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Divider datapath: load magnitudes on accept, iterate while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (flush_i) begin
            counter <= '0;
        end else if (start_div) begin
            counter   <= '0;
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
        end else if (state == DIV_BUSY) begin
            counter <= counter + SHAMT_W'(1);
            rem_q   <= rem_next;
            quo_q   <= quo_next;
        end
    end

    // Result registers: strobes default low each edge; data and HI/LO hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
            whilo_o <= 1'b0;
            wd_o    <= '0;
            wdata_o <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
            whilo_o <= 1'b0;
            if (flush_i) begin
                // strobes already cleared above
            end else if (state == DIV_BUSY && last_iter) begin
                valid_o <= 1'b1;
                whilo_o <= 1'b1;
                wdata_o <= '0;
                lo_o    <= quo_fix;
                hi_o    <= rem_fix;
            end else if (accept) begin
                wd_o <= wd_i;
                if (is_div) begin
                    if (div_zero) begin
                        valid_o <= 1'b1;
                        whilo_o <= 1'b1;
                        wdata_o <= '0;
                        lo_o    <= '1;
                        hi_o    <= reg1_i;
                    end
                end else begin
                    valid_o <= 1'b1;
                    wreg_o  <= wreg_i;
                    wdata_o <= alu_res;
                end
            end
        end
    end

endmodule
